// File: rtl/fmig_pkg.sv
// fmig_pkg: shared candidate type, default widths and the tie-rule compare
// used by the fmig_2k minimum/index tree.
package fmig_pkg;

   localparam int FMIG_BITS = 8;
   localparam int FMIG_K    = 8;
   localparam int CMP_W     = 32;   // compare width; BITS must not exceed this

   typedef struct packed {
      logic signed [FMIG_BITS-1:0] val;
      logic [FMIG_K-1:0]           idx;
   } candidate_t;

   // 1 when the right operand wins; equal values keep the left (lower index)
   function automatic logic min2(input logic signed [CMP_W-1:0] l,
                                 input logic signed [CMP_W-1:0] r);
      return r < l;
   endfunction

endpackage

// File: rtl/fmig_cmp2.sv
// fmig_cmp2: one compare/select node of the min-index tree; sets the select
// bit for its level in the forwarded partial index.
module fmig_cmp2
   import fmig_pkg::*;
#(
   parameter int BITS = FMIG_BITS,
   parameter int K    = FMIG_K,
   parameter int LVL  = 0
) (
   input  logic signed [BITS-1:0] a_val,
   input  logic [K-1:0]           a_idx,
   input  logic signed [BITS-1:0] b_val,
   input  logic [K-1:0]           b_idx,
   output logic signed [BITS-1:0] m_val,
   output logic [K-1:0]           m_idx
);

   logic sel;

   assign sel = min2(CMP_W'(a_val), CMP_W'(b_val));

   always_comb begin
      m_val      = sel ? b_val : a_val;
      m_idx      = sel ? b_idx : a_idx;
      m_idx[LVL] = sel;
   end

endmodule

// File: rtl/fmig_2k.sv
// fmig_2k: minimum and index of 2**K signed values via a binary compare tree.
// Define FMIG_PIPE_EN to register every tree level (latency K+1 instead of 1).
module fmig_2k
   import fmig_pkg::*;
#(
   parameter int BITS = FMIG_BITS,
   parameter int K    = FMIG_K
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic signed [BITS-1:0] x [2**K-1:0],
   output logic                  out_valid,
   output logic signed [BITS-1:0] out,
   output logic [K-1:0]          idx
);

   localparam int N = 2**K;

   // Heap-ordered internal nodes: node 0 is the root, children of p are 2p+1, 2p+2.
   logic signed [BITS-1:0] nv [N-1];
   logic [K-1:0]           ni [N-1];
   logic signed [BITS-1:0] sv [N-1];
   logic [K-1:0]           si [N-1];
   logic                   rv;

   for (genvar l = 0; l < K; l++) begin : g_lvl
      for (genvar j = 0; j < (N >> (l + 1)); j++) begin : g_node
         localparam int P = (N >> (l + 1)) - 1 + j;
         logic signed [BITS-1:0] av, bv;
         logic [K-1:0]           ai, bi;

         if (l == 0) begin : g_leaf
            assign av = x[2*j];
            assign bv = x[2*j+1];
            assign ai = '0;
            assign bi = '0;
         end else begin : g_inner
            assign av = sv[2*P+1];
            assign bv = sv[2*P+2];
            assign ai = si[2*P+1];
            assign bi = si[2*P+2];
         end

         fmig_cmp2 #(
            .BITS (BITS),
            .K    (K),
            .LVL  (l)
         ) u_cmp (
            .a_val (av),
            .a_idx (ai),
            .b_val (bv),
            .b_idx (bi),
            .m_val (nv[P]),
            .m_idx (ni[P])
         );
      end
   end

`ifdef FMIG_PIPE_EN
   logic [K-1:0] vs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs <= '0;
         sv <= '{default: '0};
         si <= '{default: '0};
      end else begin
         vs <= (vs << 1) | K'(in_valid);
         sv <= nv;
         si <= ni;
      end
   end

   assign rv = vs[K-1];
`else
   assign sv = nv;
   assign si = ni;
   assign rv = in_valid;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out       <= '0;
         idx       <= '0;
      end else begin
         out_valid <= rv;
         if (rv) begin
            out <= sv[0];
            idx <= si[0];
         end
      end
   end

endmodule

// File: tb/tb_fmig_2k.sv
// tb_fmig_2k: table-driven and scoreboard bench for fmig_2k at K=2 and K=8.
`timescale 1ns/1ps
module tb_fmig_2k;
   import fmig_pkg::*;

`ifdef FMIG_PIPE_EN
   localparam int LAT2 = 3;
   localparam int LAT8 = 9;
`else
   localparam int LAT2 = 1;
   localparam int LAT8 = 1;
`endif

   typedef logic signed [7:0] vec2_t [3:0];
   typedef logic signed [7:0] vec8_t [255:0];
   typedef struct {
      vec2_t            x;
      logic signed [7:0] o;
      logic [1:0]       i;
   } t2_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic iv2 = 1'b0;
   logic iv8 = 1'b0;
   vec2_t x2;
   vec8_t x8;
   logic ov2, ov8;
   logic signed [7:0] o2, o8;
   logic [1:0] i2;
   logic [7:0] i8;

   int n_tests = 0;
   int n_fail  = 0;
   candidate_t q2[$];
   candidate_t q8[$];
   logic [LAT2-1:0] vh2;
   logic [LAT8-1:0] vh8;

   bit gap_on = 0;
   int hi_cnt = 0, lo_run = 0, lo_between = 0;

   always #5 clk = ~clk;

   fmig_2k #(.BITS(8), .K(2)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv2), .x(x2),
      .out_valid(ov2), .out(o2), .idx(i2)
   );

   fmig_2k #(.BITS(8), .K(8)) u8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .x(x8),
      .out_valid(ov8), .out(o8), .idx(i8)
   );

   task automatic check(input string nm, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic candidate_t ref8(input vec8_t v);
      candidate_t c;
      logic signed [7:0] m;
      logic [7:0] k;
      m = v[0];
      k = '0;
      for (int i = 1; i < 256; i++)
         if (v[i] < m) begin
            m = v[i];
            k = 8'(i);
         end
      c.val = m;
      c.idx = k;
      return c;
   endfunction

   function automatic vec8_t rnd8(input bit ties);
      vec8_t v;
      for (int i = 0; i < 256; i++)
         v[i] = ties ? 8'($urandom_range(0, 3)) : 8'($urandom);
      return v;
   endfunction

   // Expected out_valid: in_valid delayed by the configured latency.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vh2 <= '0;
         vh8 <= '0;
      end else begin
         vh2 <= (vh2 << 1) | LAT2'(iv2);
         vh8 <= (vh8 << 1) | LAT8'(iv8);
      end
   end

   always @(negedge clk) begin
      candidate_t e;
      if (rst_n) begin
         check("valid2", ov2, vh2[LAT2-1]);
         check("valid8", ov8, vh8[LAT8-1]);
         if (ov2) begin
            if (q2.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL sb2: got unexpected result %0d required none", o2);
            end else begin
               e = q2.pop_front();
               check("out2", o2, $signed(e.val));
               check("idx2", i2, e.idx[1:0]);
            end
         end
         if (ov8) begin
            if (q8.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL sb8: got unexpected result %0d required none", o8);
            end else begin
               e = q8.pop_front();
               check("out8", o8, $signed(e.val));
               check("idx8", i8, e.idx);
            end
         end
         if (gap_on) begin
            if (ov8) begin
               hi_cnt++;
               lo_between += lo_run;
               lo_run = 0;
            end else if (hi_cnt > 0) begin
               lo_run++;
            end
         end
      end
   end

   task automatic send2(input vec2_t v, input logic signed [7:0] eo, input logic [1:0] ei);
      candidate_t c;
      @(negedge clk);
      x2 = v; iv2 = 1'b1; iv8 = 1'b0;
      c.val = eo;
      c.idx = {6'd0, ei};
      q2.push_back(c);
   endtask

   task automatic send8(input vec8_t v);
      @(negedge clk);
      x8 = v; iv8 = 1'b1; iv2 = 1'b0;
      q8.push_back(ref8(v));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         iv2 = 1'b0; iv8 = 1'b0;
      end
   endtask

   task automatic drain();
      int c = 0;
      while ((q2.size() != 0 || q8.size() != 0) && c < 50) begin
         idle(1);
         c++;
      end
      n_tests++;
      if (q2.size() != 0 || q8.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d/%0d results outstanding required 0/0", q2.size(), q8.size());
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ov2"}, ov2, 0);
      check({tag, "_out2"}, o2, 0);
      check({tag, "_idx2"}, i2, 0);
      check({tag, "_ov8"}, ov8, 0);
      check({tag, "_out8"}, o8, 0);
      check({tag, "_idx8"}, i8, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no summary required finish");
      $fatal(1, "timeout");
   end

   initial begin
      t2_t tbl[6];
      vec8_t d8, p8;

      x2 = '{default: '0};
      x8 = '{default: '0};

      tbl[0].x = '{8'sd5, -8'sd3, 8'sd7, 8'sd2};   tbl[0].o = -8'sd3;  tbl[0].i = 2'd2;
      tbl[1].x = '{8'sd4, 8'sd4, 8'sd4, 8'sd4};    tbl[1].o = 8'sd4;   tbl[1].i = 2'd0;
      tbl[2].x = '{8'sh80, 8'sh7f, 8'sh80, 8'sd0}; tbl[2].o = 8'sh80;  tbl[2].i = 2'd1;
      tbl[3].x = '{-8'sd2, -8'sd1, -8'sd1, -8'sd1}; tbl[3].o = -8'sd2; tbl[3].i = 2'd3;
      tbl[4].x = '{-8'sd5, 8'sd9, 8'sd3, -8'sd6};  tbl[4].o = -8'sd6;  tbl[4].i = 2'd0;
      tbl[5].x = '{8'sh7f, 8'sh7f, 8'sh7f, 8'sh7f}; tbl[5].o = 8'sh7f; tbl[5].i = 2'd0;

      // Reset asserted from time 0: outputs must be clear before the first edge.
      #2;
      check_zero("rst0");
      @(negedge clk);
      rst_n = 1'b1;

      for (int t = 0; t < 6; t++) begin
         send2(tbl[t].x, tbl[t].o, tbl[t].i);
         idle(LAT2 + 1);
      end
      drain();

      d8 = '{default: 8'sd100};
      d8[200] = -8'sd50;
      d8[37]  = -8'sd50;
      send8(d8);
      idle(LAT8 + 1);
      drain();

      for (int t = 0; t < 40; t++) send8(rnd8(t[2]));
      drain();

      gap_on = 1;
      for (int t = 0; t < 20; t++) send8(rnd8(1'b0));
      idle(1);
      for (int t = 0; t < 20; t++) send8(rnd8(t[0]));
      drain();
      idle(2);
      gap_on = 0;
      check("gap_lows", lo_between, 1);
      check("gap_highs", hi_cnt, 40);

      send8(d8);
      send2(tbl[4].x, tbl[4].o, tbl[4].i);
      drain();
      for (int t = 0; t < 3; t++) send8(rnd8(1'b0));
      send2(tbl[0].x, tbl[0].o, tbl[0].i);
      @(negedge clk);
      iv2 = 1'b0; iv8 = 1'b0;
      #2;
      rst_n = 1'b0;
      q2.delete();
      q8.delete();
      #1;
      check_zero("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;

      p8 = '{default: 8'sd10};
      p8[255] = -8'sd1;
      send8(p8);
      send2(tbl[2].x, tbl[2].o, tbl[2].i);
      drain();
      idle(LAT8 + 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
